// File: rtl/chip8_pkg.sv
// Shared constants and loader state encoding for the CHIP-8 program memory.
package chip8_pkg;

  localparam int unsigned CHIP8_ADDR_WIDTH = 12;
  localparam int unsigned CHIP8_DATA_WIDTH = 8;
  localparam int unsigned CHIP8_LOAD_BASE  = 32'h200;
  localparam int unsigned CHIP8_MEM_DEPTH  = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/chip8_program_mem_if.sv
// Loader stream and CPU memory port bundle for chip8_program_mem.
interface chip8_program_mem_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_busy;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_WIDTH-1:0] prog_len;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Host/CPU side
  modport master (
    output load_start, load_valid, load_data, load_last,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  load_ready, load_busy, load_done, load_error, prog_len, rd_data
  );

  // Memory side
  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output load_ready, load_busy, load_done, load_error, prog_len, rd_data
  );

endinterface

// File: rtl/chip8_bram.sv
// Single-clock simple dual-port RAM, read-first, registered read data.
module chip8_bram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register samples old contents on a same-address write; holds when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/chip8_program_mem.sv
// CHIP-8 program RAM with a streaming loader and a CPU read/write port.
module chip8_program_mem
  import chip8_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = CHIP8_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH    = CHIP8_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE     = ADDR_WIDTH'(CHIP8_LOAD_BASE),
  parameter bit                    CLEAR_ON_LOAD = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  chip8_program_mem_if.slave bus
);

  localparam int unsigned           PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] LEN_MAX   = '1;

  load_state_e            state, state_nx;
  logic [PTR_WIDTH-1:0]   ptr, ptr_nx;
  logic [ADDR_WIDTH-1:0]  len_nx;
  logic                   err_nx;
  logic                   ldr_we_c;
  logic [DATA_WIDTH-1:0]  ldr_data_c;
  logic                   busy_c;
  logic                   mem_we_c;
  logic [ADDR_WIDTH-1:0]  mem_waddr_c;
  logic [DATA_WIDTH-1:0]  mem_wdata_c;

  // Loader next-state and RAM write request
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    len_nx     = bus.prog_len;
    err_nx     = bus.load_error;
    ldr_we_c   = 1'b0;
    ldr_data_c = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_nx = CLEAR_ON_LOAD ? ST_CLEAR : ST_LOAD;
          ptr_nx   = {1'b0, LOAD_BASE};
          len_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      ST_CLEAR: begin
        ldr_we_c = 1'b1;
        if (ptr[ADDR_WIDTH-1:0] == TOP_ADDR) begin
          ptr_nx   = {1'b0, LOAD_BASE};
          state_nx = ST_LOAD;
        end else begin
          ptr_nx = ptr + PTR_WIDTH'(1);
        end
      end
      ST_LOAD: begin
        if (bus.load_valid) begin
          // Carry bit set means the image ran past the top address
          if (!ptr[ADDR_WIDTH]) begin
            ldr_we_c   = 1'b1;
            ldr_data_c = bus.load_data;
            ptr_nx     = ptr + PTR_WIDTH'(1);
            if (bus.prog_len != LEN_MAX) len_nx = bus.prog_len + ADDR_WIDTH'(1);
          end else begin
            err_nx = 1'b1;
          end
          if (bus.load_last) state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Loader state, pointer and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      bus.prog_len   <= '0;
      bus.load_error <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.load_busy  <= 1'b0;
      bus.load_done  <= 1'b0;
    end else begin
      state          <= state_nx;
      ptr            <= ptr_nx;
      bus.prog_len   <= len_nx;
      bus.load_error <= err_nx;
      bus.load_ready <= (state_nx == ST_LOAD);
      bus.load_busy  <= (state_nx == ST_CLEAR) || (state_nx == ST_LOAD);
      bus.load_done  <= (state_nx == ST_DONE);
    end
  end

  // Write port arbitration: loader owns the RAM while busy, CPU otherwise
  always_comb begin
    busy_c      = (state == ST_CLEAR) || (state == ST_LOAD);
    mem_we_c    = 1'b0;
    mem_waddr_c = bus.wr_addr;
    mem_wdata_c = bus.wr_data;
    if (busy_c) begin
      mem_we_c    = ldr_we_c;
      mem_waddr_c = ptr[ADDR_WIDTH-1:0];
      mem_wdata_c = ldr_data_c;
    end else begin
      mem_we_c = bus.wr_en;
    end
  end

  chip8_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (mem_we_c),
    .waddr   (mem_waddr_c),
    .wdata   (mem_wdata_c),
    .re      (bus.rd_en),
    .raddr   (bus.rd_addr),
    .rdata   (bus.rd_data)
  );

endmodule

// File: doc/chip8_program_mem.md
# chip8_program_mem

Parametrised CHIP-8 program memory with a built-in streaming loader. It replaces fixed, hard-coded test ROMs. A host pushes a program image as a byte stream with a valid/ready handshake, and the block writes it into RAM starting at LOAD_BASE, optionally clearing memory first. Once loading completes, the block serves the CPU core with a synchronous read port and a write port used by Fx55/Fx33.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte address width. Memory depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8: byte width.
- LOAD_BASE, 12'h200: first address written by the loader.
- CLEAR_ON_LOAD, 1: when 1, zero the range LOAD_BASE..top before loading.

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- load_start, in, 1: begin a load. Ignored unless the FSM is in IDLE.
- load_valid, in, 1: load_data is valid this cycle.
- load_data, in, DATA_WIDTH: program byte.
- load_last, in, 1: qualifies the final byte of the image.
- load_ready, out, 1: block accepts a byte this cycle.
- load_busy, out, 1: high in CLEAR or LOAD. The CPU must stall while it is high.
- load_done, out, 1: one-cycle pulse when a load ends.
- load_error, out, 1: sticky overflow flag. Cleared by load_start or reset.
- prog_len, out, ADDR_WIDTH: number of bytes written by the last load, saturating.
- rd_en, in, 1: CPU read strobe.
- rd_addr, in, ADDR_WIDTH: CPU read address.
- rd_data, out, DATA_WIDTH: read result, valid one cycle after rd_en.
- wr_en, in, 1: CPU write strobe.
- wr_addr, in, ADDR_WIDTH: CPU write address.
- wr_data, in, DATA_WIDTH: CPU write data.

## Operation
- FSM states are IDLE, CLEAR, LOAD and DONE.
- Reset value: IDLE. All outputs reset to 0.
- Memory contents are not affected by reset.
- IDLE:
  - load_start goes to CLEAR if CLEAR_ON_LOAD is 1, otherwise to LOAD.
  - On entry from load_start: pointer ← LOAD_BASE, prog_len ← 0, load_error ← 0.
- CLEAR:
  - Writes 0 at the pointer each cycle, then increments the pointer.
  - After writing address 2^ADDR_WIDTH−1, the pointer returns to LOAD_BASE and the FSM moves to LOAD.
- LOAD:
  - load_ready = 1.
  - An accepted byte (load_valid & load_ready) is written at the pointer. The pointer and prog_len then increment.
  - If the pointer has already wrapped past the top address, the byte is dropped and load_error is set. Writes never wrap into 0..LOAD_BASE−1.
  - Accepting a byte with load_last high moves the FSM to DONE.
- DONE: load_done = 1 for exactly one cycle, then IDLE.
- CPU port:
  - Writes are ignored while load_busy is high.
  - Reads are always serviced; contents are undefined while a load is in progress.
- Read-during-write to the same address returns the old data (read-first).
- load_start while busy is ignored. Reset asserted mid-load returns the FSM to IDLE immediately; a partial image stays in memory.
- Pointer arithmetic uses ADDR_WIDTH+1 bits, so overflow is detected by the carry bit.

## Timing
- Read latency is 1 cycle. rd_data holds its value while rd_en is low.
- Load throughput is 1 byte per cycle. load_ready depends only on the FSM state; it has no combinational path from load_valid.
- CLEAR takes 2^ADDR_WIDTH − LOAD_BASE cycles. With defaults: 3584 cycles.
- load_busy falls in the same cycle that load_done pulses.
- CPU write data is visible to a read issued in the following cycle.

## Structure
- Shared package chip8_pkg holds:
  - the CHIP8_LOAD_BASE and CHIP8_MEM_DEPTH constants;
  - the loader state enum typedef (IDLE/CLEAR/LOAD/DONE).
- One sub-module, chip8_bram: a single-clock RAM with one write port and one read port, read-first, inferable.
- The top level arbitrates the RAM write port between the loader and the CPU.

## Test plan
- Reset, then load an 18-byte image (60 EA 61 AC 62 AA 63 E9 A0 00 F3 55 A0 00 60 00 D0 04) with load_last on the last byte. Required:
  - prog_len = 18 and load_done pulses once;
  - a read of 0x200 returns 0x60, and a read of 0x211 returns 0x04 one cycle after rd_en;
  - a read of 0x212 returns 0x00 (cleared).
- Stream bytes with random load_valid gaps. Required: all bytes land in order and no byte is duplicated or lost.
- Load 3586 bytes. Required:
  - load_error = 1 and prog_len = 3584;
  - address 0x000 is unchanged;
  - address 0xFFF holds byte 3584.
- After a load, issue a CPU write of 0x5A to 0x300 with a simultaneous read of 0x300. Required: the read returns the old value, and the next read returns 0x5A.
- Assert reset_n low during CLEAR at pointer 0x400. Required: the FSM is in IDLE, all outputs are 0, and a following load completes normally.
- Pulse load_start during LOAD, and issue a CPU wr_en while busy. Required: both are ignored and the image is intact.
